// File: rtl/clk_div_multi_if.sv
// clk_div_multi_if: control and status bundle for the multi-channel clock divider.
interface clk_div_multi_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32
);
    localparam int WCH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0] en;
    logic              sync;
    logic              wr_en;
    logic [WCH_W-1:0]  wr_ch;
    logic [CNT_W-1:0]  wr_div;
    logic [NUM_CH-1:0] wave;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] pending;

    modport master (output en, sync, wr_en, wr_ch, wr_div, input wave, tick, pending);
    modport slave  (input en, sync, wr_en, wr_ch, wr_div, output wave, tick, pending);
endinterface

// File: rtl/clk_div_multi.sv
// clk_div_multi: NUM_CH programmable half-period dividers with tick strobes.
// Divisor writes land in a shadow register and are adopted only at a wrap or sync.
module clk_div_multi #(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 32,
    parameter int DEFAULT_DIV = 25_000_000
) (
    input  logic           clk,
    input  logic           rst,
    clk_div_multi_if.slave bus
);
    localparam int WCH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
    localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);

    logic [CNT_W-1:0]  cnt_q[NUM_CH], cnt_d[NUM_CH];
    logic [CNT_W-1:0]  shadow_q[NUM_CH], shadow_d[NUM_CH];
    logic [CNT_W-1:0]  active_q[NUM_CH], active_d[NUM_CH];
    logic [NUM_CH-1:0] wave_q, wave_d, tick_q, tick_d, wrap, pending;

    // A divisor of zero behaves as one, so the last count is then 0.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            wrap[i]     = bus.en[i] && cnt_q[i] == (active_q[i] == '0 ? '0 : active_q[i] - 1'b1);
            cnt_d[i]    = bus.sync ? '0 : !bus.en[i] ? cnt_q[i] : wrap[i] ? '0 : cnt_q[i] + 1'b1;
            wave_d[i]   = bus.sync ? 1'b0 : wrap[i] ? ~wave_q[i] : wave_q[i];
            tick_d[i]   = !bus.sync && wrap[i];
            active_d[i] = (bus.sync || wrap[i]) ? shadow_q[i] : active_q[i];
            shadow_d[i] = (bus.wr_en && bus.wr_ch == WCH_W'(i)) ? bus.wr_div : shadow_q[i];
            pending[i]  = shadow_q[i] != active_q[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '{default: '0};
            shadow_q <= '{default: DIV_RST};
            active_q <= '{default: DIV_RST};
            wave_q   <= '0;
            tick_q   <= '0;
        end else begin
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            wave_q   <= wave_d;
            tick_q   <= tick_d;
        end
    end

    assign bus.wave    = wave_q;
    assign bus.tick    = tick_q;
    assign bus.pending = pending;
endmodule

// File: tb/tb_clk_div_multi.sv
// tb_clk_div_multi: directed and random checks against a countdown reference model.
module tb_clk_div_multi;
    localparam int NUM_CH = 3;
    localparam int CNT_W  = 8;
    localparam int DEF    = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;

    clk_div_multi_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();
    clk_div_multi #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEFAULT_DIV(DEF)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    always #5 clk = ~clk;

    // Model: cycles left until the next edge, rather than a count-up register.
    int                rem[NUM_CH];
    logic [CNT_W-1:0]  m_sh[NUM_CH], m_act[NUM_CH];
    logic [NUM_CH-1:0] m_wave, m_tick, m_pend;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int eff(input logic [CNT_W-1:0] v);
        return v == 0 ? 1 : int'(v);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            m_sh[i] = CNT_W'(DEF); m_act[i] = CNT_W'(DEF); rem[i] = DEF;
        end
        m_wave = '0; m_tick = '0;
    endtask

    task automatic model_step();
        for (int i = 0; i < NUM_CH; i++) begin
            m_tick[i] = 1'b0;
            if (bus.sync) begin
                m_act[i] = m_sh[i]; rem[i] = eff(m_sh[i]); m_wave[i] = 1'b0;
            end else if (bus.en[i]) begin
                rem[i]--;
                if (rem[i] == 0) begin
                    m_tick[i] = 1'b1; m_wave[i] = ~m_wave[i];
                    m_act[i] = m_sh[i]; rem[i] = eff(m_act[i]);
                end
            end
        end
        if (bus.wr_en && int'(bus.wr_ch) < NUM_CH) m_sh[bus.wr_ch] = bus.wr_div;
    endtask

    task automatic step();
        model_step();
        @(posedge clk); #1;
        for (int i = 0; i < NUM_CH; i++) m_pend[i] = m_sh[i] != m_act[i];
        chk("wave", 32'(bus.wave), 32'(m_wave));
        chk("tick", 32'(bus.tick), 32'(m_tick));
        chk("pending", 32'(bus.pending), 32'(m_pend));
    endtask

    task automatic wr(input int ch, input int d);
        bus.wr_en = 1'b1; bus.wr_ch = 2'(ch); bus.wr_div = CNT_W'(d);
        step();
        bus.wr_en = 1'b0;
    endtask

    task automatic do_sync();
        bus.sync = 1'b1;
        step();
        bus.sync = 1'b0;
    endtask

    initial begin
        logic w2;
        bit   found;
        bus.en = '1; bus.sync = 1'b0; bus.wr_en = 1'b0; bus.wr_ch = '0; bus.wr_div = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wave", 32'(bus.wave), 0);
        chk("rst_tick", 32'(bus.tick), 0);
        chk("rst_pend", 32'(bus.pending), 0);
        @(negedge clk) rst = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            step();
            chk("first_ticks", 32'(bus.tick), (k % 3 == 0) ? 32'h7 : 32'h0);
            chk("first_wave", 32'(bus.wave), ((k / 3) % 2 == 1) ? 32'h7 : 32'h0);
        end

        // Divisor change on ch0 takes effect only at the wrap.
        wr(0, 4);
        do_sync();
        step(); step();
        wr(0, 2);
        chk("chg_pend", 32'(bus.pending[0]), 1);
        step();
        chk("chg_tick_old", 32'(bus.tick[0]), 1);
        chk("chg_pend_clr", 32'(bus.pending[0]), 0);
        step();
        chk("chg_tick_gap", 32'(bus.tick[0]), 0);
        step();
        chk("chg_tick_new", 32'(bus.tick[0]), 1);

        // Zero divisor runs at one, and an out-of-range write is ignored.
        wr(1, 0);
        do_sync();
        for (int k = 0; k < 4; k++) begin
            step();
            chk("zero_tick", 32'(bus.tick[1]), 1);
            chk("zero_wave", 32'(bus.wave[1]), (k % 2 == 0) ? 1 : 0);
        end
        wr(NUM_CH, 7);
        chk("oor_pend", 32'(bus.pending), 0);

        // Enable gating freezes the phase of ch2.
        wr(2, 5);
        do_sync();
        step(); step();
        w2 = m_wave[2];
        bus.en[2] = 1'b0;
        for (int k = 0; k < 7; k++) begin
            step();
            chk("gate_tick", 32'(bus.tick[2]), 0);
            chk("gate_wave", 32'(bus.wave[2]), 32'(w2));
        end
        bus.en[2] = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step();
            chk("resume_tick", 32'(bus.tick[2]), (k == 3) ? 1 : 0);
        end

        // Sync coinciding with a ch0 wrap and a ch0 write.
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (rem[0] == 1) found = 1'b1;
            else step();
        end
        chk("phase_search", 32'(found), 1);
        bus.sync = 1'b1; bus.wr_en = 1'b1; bus.wr_ch = 2'd0; bus.wr_div = 8'd6;
        step();
        bus.sync = 1'b0; bus.wr_en = 1'b0;
        chk("sync_tick", 32'(bus.tick), 0);
        chk("sync_wave", 32'(bus.wave), 0);
        chk("sync_pend0", 32'(bus.pending[0]), 1);

        for (int k = 0; k < 400; k++) begin
            bus.en     = NUM_CH'($urandom_range(0, 7) | ($urandom_range(0, 3) == 0 ? 0 : 7));
            bus.sync   = $urandom_range(0, 30) == 0;
            bus.wr_en  = $urandom_range(0, 5) == 0;
            bus.wr_ch  = 2'($urandom_range(0, 3));
            bus.wr_div = CNT_W'($urandom_range(0, 6));
            step();
        end
        bus.en = '1; bus.sync = 1'b0; bus.wr_en = 1'b0;

        // Asynchronous reset between edges while a tick is high.
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            step();
            if (m_tick != '0) found = 1'b1;
        end
        chk("tick_search", 32'(found), 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_tick", 32'(bus.tick), 0);
        chk("arst_wave", 32'(bus.wave), 0);
        chk("arst_pend", 32'(bus.pending), 0);
        model_reset();
        @(negedge clk) rst = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            step();
            chk("arst_period", 32'(bus.tick), (k % 3 == 0) ? 32'h7 : 32'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/clk_div_multi.md
# clk_div_multi

Multi-channel programmable clock divider: the parametrised successor of the fixed 1 Hz divider. Each of NUM_CH channels has a runtime-writable half-period divisor, a per-channel enable, a square-wave output and a single-cycle tick strobe. A global sync input realigns all channels. It sits beside the system clock and feeds display multiplexing, debouncers and slow-state logic with enable strobes and divided waves.

## Interface

Parameters:
- NUM_CH, 4: number of independent channels (1..16).
- CNT_W, 32: counter and divisor width.
- DEFAULT_DIV, 25_000_000: half-period divisor loaded at reset. At 50 MHz this gives a 1 Hz wave.

Ports:
- clk, in, 1: system clock; all logic on its rising edge.
- rst, in, 1: asynchronous, active-high reset.
- en, in, NUM_CH: per-channel count enable.
- sync, in, 1: synchronous realign of all channels.
- wr_en, in, 1: divisor write strobe.
- wr_ch, in, $clog2(NUM_CH) (min 1): channel index for the write.
- wr_div, in, CNT_W: new half-period divisor.
- wave, out, NUM_CH: divided square waves, period 2·D cycles.
- tick, out, NUM_CH: one-cycle strobe at each wave edge, period D cycles.
- pending, out, NUM_CH: shadow divisor differs from active divisor.

## Operation

- Per-channel state:
  - cnt[CNT_W]
  - div_shadow[CNT_W], the write target
  - div_active[CNT_W], in use
  - wave
  - tick
- Effective divisor: D = max(div_active, 1). A written value of 0 behaves as 1.
- Write: when wr_en=1 and wr_ch<NUM_CH, div_shadow[wr_ch] <= wr_div. When wr_ch≥NUM_CH the write is ignored with no side effects. div_active is never written directly.
- Count, when en[i]=1 and sync=0:
  - If cnt==D-1: cnt<=0, wave toggles, tick<=1, and div_active<=div_shadow. This is a glitch-free divisor change at the wrap boundary.
  - Otherwise: cnt<=cnt+1, tick<=0.
- When en[i]=0: cnt and wave hold, tick<=0, and div_active does not update.
- Sync has priority over count and enable, on all channels:
  - cnt<=0, wave<=0, tick<=0
  - div_active<=div_shadow
- Write in the same cycle as a wrap or sync: div_active takes the pre-write div_shadow value. The new write value applies at the next wrap or sync.
- If div_active is reduced below the current cnt, no overflow lockup occurs. Because the divisor only changes at the wrap, cnt is always ≤ D-1.
- pending[i] = (div_shadow[i] != div_active[i]). This is combinational from registers.
- Reset values:
  - cnt=0, wave=0, tick=0
  - div_shadow=div_active=DEFAULT_DIV
  - pending=0

## Timing

- All outputs are registered except pending, which is derived from registers only.
- From reset release or sync, with en held high, the first tick is high in the cycle after the D-th rising edge. The next ticks follow every D cycles.
- wave changes on the same edge that raises tick. It is high for D cycles and low for D cycles.
- Write-to-effect latency: a write lands in div_shadow on the next edge. It takes effect at the following wrap, so at most D_old cycles plus 1 later, or immediately on sync.
- Deasserting en freezes phase. Reasserting en resumes counting from the held cnt.
- Asserting rst mid-period clears everything asynchronously. tick and wave drop with no clock.

## Test plan

- Reset defaults: assert rst, then release with DEFAULT_DIV overridden to 3 and en=all ones.
  - wave=0, tick=0, pending=0 during rst.
  - tick high after edges 3, 6 and 9.
  - wave toggles on those same edges.
- Divisor change at boundary: ch0 running D=4, write wr_div=2 to ch0 mid-period.
  - pending[0]=1 until the next wrap.
  - The current period still completes at 4 cycles.
  - Subsequent ticks are every 2 cycles, and pending[0] returns to 0.
- Zero divisor and out-of-range write: write 0 to ch1, then sync.
  - tick[1]=1 on every cycle and wave[1] toggles every cycle.
  - Then write with wr_ch=NUM_CH: no divisor changes on any channel.
- Enable gating: running D=5 ch2, drop en[2] for 7 cycles at cnt=2.
  - tick[2]=0 and wave[2] holds throughout.
  - After reasserting en[2], the next tick arrives 3 cycles later.
- Sync and simultaneous events: channels at different phases.
  - Assert sync in the same cycle as a wrap on ch0 and a write to ch0. All channels reset to cnt 0 with wave=0, and no tick in that cycle.
  - ch0 uses the pre-write shadow value, and pending[0]=1 afterwards.
- Async reset mid-operation: assert rst between clock edges while tick is high.
  - tick, wave and pending drop immediately.
  - The divisors return to DEFAULT_DIV.
